// File: rtl/verifier_interface_arb_pkg.sv
// Shared types and constants for verifier_interface_arb.
// Optional watchdog build: define VIF_ARB_TIMEOUT_EN.
`ifndef F_NBITS
`define F_NBITS 64
`endif

package vif_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_COLLECT = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int REQ_TYPE_W = 4;

    localparam int              WD_W     = 16;
    localparam logic [WD_W-1:0] WD_LIMIT = 16'hFFFF;

endpackage

// File: rtl/verifier_interface_arb_if.sv
// Client request/response and verifier port bundle for verifier_interface_arb.
// slave = the arbiter side, master = clients plus verifier side.
interface verifier_interface_arb_if
    import vif_arb_pkg::*;
#(
    parameter int nreq   = 4,
    parameter int nwords = 8,
    parameter int wbits  = $clog2(nwords + 1)
);

    logic [nreq-1:0]                       req_valid;
    logic [nreq-1:0][REQ_TYPE_W-1:0]       req_type;
    logic [nreq-1:0][31:0]                 req_id;
    logic [nreq-1:0][wbits-1:0]            req_nwords;
    logic [nreq-1:0]                       grant;
    logic [nreq-1:0]                       resp_valid;
    logic                                  resp_err;
    logic [nwords-1:0][`F_NBITS-1:0]       resp_data;
    logic                                  v_req;
    logic [REQ_TYPE_W-1:0]                 v_type;
    logic [31:0]                           v_id;
    logic [wbits-1:0]                      v_nwords;
    logic                                  v_ack;
    logic                                  v_data_valid;
    logic [`F_NBITS-1:0]                   v_data;

    modport slave (
        input  req_valid, req_type, req_id, req_nwords, v_ack, v_data_valid, v_data,
        output grant, resp_valid, resp_err, resp_data, v_req, v_type, v_id, v_nwords
    );

    modport master (
        output req_valid, req_type, req_id, req_nwords, v_ack, v_data_valid, v_data,
        input  grant, resp_valid, resp_err, resp_data, v_req, v_type, v_id, v_nwords
    );

endinterface

// File: rtl/verifier_interface_arb_rr_pick.sv
// Combinational round-robin selector: first requester at or after rr_ptr, wrapping.
module vif_rr_pick #(
    parameter  int nreq = 4,
    localparam int IW   = $clog2(nreq)
) (
    input  logic [nreq-1:0] req_valid,
    input  logic [IW-1:0]   rr_ptr,
    output logic            any,
    output logic [nreq-1:0] onehot,
    output logic [IW-1:0]   index
);

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin : p_pick
        int pos;
        any    = 1'b0;
        index  = {IW{1'b0}};
        onehot = {nreq{1'b0}};
        pos    = 0;
        for (int i = nreq - 1; i >= 0; i--) begin
            pos   = int'(rr_ptr) + i;
            pos   = (pos >= nreq) ? pos - nreq : pos;
            any   = any | req_valid[pos];
            index = req_valid[pos] ? IW'(pos) : index;
        end
        for (int k = 0; k < nreq; k++) begin
            onehot[k] = any && (index == IW'(k));
        end
    end

endmodule

// File: rtl/verifier_interface_arb.sv
// Round-robin arbiter/sequencer for the single verifier request channel.
// Define VIF_ARB_TIMEOUT_EN to enable the 16-bit ISSUE/COLLECT watchdog.
module verifier_interface_arb
    import vif_arb_pkg::*;
#(
    parameter int nreq   = 4,
    parameter int nwords = 8,
    parameter int wbits  = $clog2(nwords + 1)
) (
    input  logic                     clk,
    input  logic                     rstb,
    verifier_interface_arb_if.slave  bus
);

    localparam int               IW        = $clog2(nreq);
    localparam logic [IW-1:0]    LAST_IDX  = IW'(nreq - 1);
    localparam logic [wbits-1:0] MAX_WORDS = wbits'(nwords);

    if (wbits != $clog2(nwords + 1)) begin : g_wbits_check
        $error("verifier_interface_arb: wbits must equal $clog2(nwords+1)");
    end

    state_t                          state_r, state_s;
    logic [IW-1:0]                   rr_ptr_r, owner_r;
    logic [nreq-1:0]                 grant_r, resp_valid_r;
    logic                            resp_err_r, v_req_r;
    logic [nwords-1:0][`F_NBITS-1:0] resp_data_r;
    logic [REQ_TYPE_W-1:0]           v_type_r;
    logic [31:0]                     v_id_r;
    logic [wbits-1:0]                v_nwords_r, cnt_r;
    logic                            pick_any_s, wd_expire_s, word_wr_s;
    logic [nreq-1:0]                 pick_onehot_s;
    logic [IW-1:0]                   pick_idx_s;

    vif_rr_pick #(.nreq(nreq)) u_pick (
        .req_valid (bus.req_valid),
        .rr_ptr    (rr_ptr_r),
        .any       (pick_any_s),
        .onehot    (pick_onehot_s),
        .index     (pick_idx_s)
    );

`ifdef VIF_ARB_TIMEOUT_EN
    logic [WD_W-1:0] wd_r;
    logic            err_r;
    assign wd_expire_s = (wd_r == WD_LIMIT);
`else
    assign wd_expire_s = 1'b0;
`endif

    // Once the last expected word is in (cnt == nwords), further data is ignored.
    assign word_wr_s = (state_r == ST_COLLECT) && bus.v_data_valid && (cnt_r != v_nwords_r);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_any_s) state_s = ST_ISSUE;
                else            state_s = ST_IDLE;
            end
            ST_ISSUE: begin
                if (bus.v_ack)        state_s = (v_nwords_r == {wbits{1'b0}}) ? ST_DONE : ST_COLLECT;
                else if (wd_expire_s) state_s = ST_DONE;
                else                  state_s = ST_ISSUE;
            end
            ST_COLLECT: begin
                if (cnt_r == v_nwords_r) state_s = ST_DONE;
                else if (wd_expire_s)    state_s = ST_DONE;
                else                     state_s = ST_COLLECT;
            end
            ST_DONE:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Latched request fields, response capture and registered outputs.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            rr_ptr_r     <= {IW{1'b0}};
            owner_r      <= {IW{1'b0}};
            grant_r      <= {nreq{1'b0}};
            resp_valid_r <= {nreq{1'b0}};
            resp_err_r   <= 1'b0;
            resp_data_r  <= '0;
            v_req_r      <= 1'b0;
            v_type_r     <= {REQ_TYPE_W{1'b0}};
            v_id_r       <= 32'd0;
            v_nwords_r   <= {wbits{1'b0}};
            cnt_r        <= {wbits{1'b0}};
`ifdef VIF_ARB_TIMEOUT_EN
            wd_r         <= {WD_W{1'b0}};
            err_r        <= 1'b0;
`endif
        end else begin
            resp_valid_r <= {nreq{1'b0}};
            resp_err_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pick_any_s) begin
                        owner_r    <= pick_idx_s;
                        grant_r    <= pick_onehot_s;
                        v_req_r    <= 1'b1;
                        v_type_r   <= bus.req_type[pick_idx_s];
                        v_id_r     <= bus.req_id[pick_idx_s];
                        v_nwords_r <= (bus.req_nwords[pick_idx_s] > MAX_WORDS) ?
                                      MAX_WORDS : bus.req_nwords[pick_idx_s];
                        cnt_r      <= {wbits{1'b0}};
`ifdef VIF_ARB_TIMEOUT_EN
                        wd_r       <= {WD_W{1'b0}};
                        err_r      <= 1'b0;
`endif
                    end
                end
                ST_ISSUE: begin
                    if (bus.v_ack) begin
                        v_req_r <= 1'b0;
`ifdef VIF_ARB_TIMEOUT_EN
                        wd_r    <= {WD_W{1'b0}};
`endif
                    end else if (wd_expire_s) begin
                        v_req_r <= 1'b0;
`ifdef VIF_ARB_TIMEOUT_EN
                        err_r   <= 1'b1;
`endif
                    end else begin
`ifdef VIF_ARB_TIMEOUT_EN
                        wd_r    <= wd_r + 16'd1;
`endif
                    end
                end
                ST_COLLECT: begin
                    for (int k = 0; k < nwords; k++) begin
                        if (word_wr_s && (cnt_r == wbits'(k))) resp_data_r[k] <= bus.v_data;
                    end
                    if (word_wr_s) cnt_r <= cnt_r + wbits'(1);
`ifdef VIF_ARB_TIMEOUT_EN
                    if (word_wr_s)                                   wd_r  <= {WD_W{1'b0}};
                    else if (wd_expire_s && (cnt_r != v_nwords_r))  err_r <= 1'b1;
                    else                                             wd_r  <= wd_r + 16'd1;
`endif
                end
                ST_DONE: begin
                    resp_valid_r <= grant_r;
`ifdef VIF_ARB_TIMEOUT_EN
                    resp_err_r   <= err_r;
`endif
                    grant_r      <= {nreq{1'b0}};
                    rr_ptr_r     <= (owner_r == LAST_IDX) ? {IW{1'b0}} : owner_r + IW'(1);
                end
                default: begin
                    grant_r <= {nreq{1'b0}};
                    v_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant      = grant_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_err   = resp_err_r;
    assign bus.resp_data  = resp_data_r;
    assign bus.v_req      = v_req_r;
    assign bus.v_type     = v_type_r;
    assign bus.v_id       = v_id_r;
    assign bus.v_nwords   = v_nwords_r;

endmodule

// File: tb/tb_verifier_interface_arb.sv
// Randomized self-checking bench for verifier_interface_arb against a transaction-level model.
`ifndef F_NBITS
`define F_NBITS 64
`endif

module tb_verifier_interface_arb;

    logic clk = 1'b0;
    logic rstb;
    always #5 clk = ~clk;

    verifier_interface_arb_if bus ();

    verifier_interface_arb dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    // Model: pending requests, round-robin pointer and response memory image.
    bit                   pend [4];
    logic [3:0]           typ  [4];
    logic [31:0]          idv  [4];
    logic [3:0]           nwv  [4];
    int                   ptr;
    logic [`F_NBITS-1:0]  exp_mem [8];
    logic [`F_NBITS-1:0]  fixed_q [$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reqs();
        for (int i = 0; i < 4; i++) begin
            bus.req_valid[i]  = pend[i];
            bus.req_type[i]   = typ[i];
            bus.req_id[i]     = idv[i];
            bus.req_nwords[i] = nwv[i];
        end
    endtask

    function automatic int pick_owner();
        for (int i = 0; i < 4; i++) begin
            if (pend[(ptr + i) % 4]) return (ptr + i) % 4;
        end
        return 0;
    endfunction

    task automatic model_reset();
        ptr = 0;
        for (int k = 0; k < 8; k++) exp_mem[k] = '0;
    endtask

    task automatic set_req(input int c, input logic [3:0] t, input logic [31:0] id, input logic [3:0] n);
        pend[c] = 1'b1; typ[c] = t; idv[c] = id; nwv[c] = n;
    endtask

    // One full transaction from the IDLE edge through the completion pulse.
    task automatic run_txn(input int ack_dly, input int max_gap, input bit drop_mid);
        int own, n, cyc, gaps, g;
        logic [3:0] oh;
        logic [`F_NBITS-1:0] w;
        own = pick_owner();
        oh  = 4'b0001 << own;
        n   = (nwv[own] > 4'd8) ? 8 : int'(nwv[own]);
        step(); cyc = 0; gaps = 0;
        check_val("grant", bus.grant, oh);
        check_val("v_req_on", bus.v_req, 1);
        check_val("v_type", bus.v_type, typ[own]);
        check_val("v_id", bus.v_id, idv[own]);
        check_val("v_nwords", bus.v_nwords, n);
        check_val("no_early_resp", bus.resp_valid, 0);
        bus.v_data_valid = 1'b1;
        bus.v_data = {$urandom, $urandom};
        for (int d = 0; d < ack_dly; d++) begin
            step(); cyc++;
            check_val("v_req_hold", bus.v_req, 1);
        end
        bus.v_data_valid = 1'b0;
        bus.v_ack = 1'b1;
        step(); cyc++;
        bus.v_ack = 1'b0;
        check_val("v_req_off", bus.v_req, 0);
        if (drop_mid) begin
            pend[own] = 1'b0;
            bus.req_valid[own] = 1'b0;
        end
        if (n == 0) begin
            step(); cyc++;
        end else begin
            for (int k = 0; k < n; k++) begin
                g = $urandom_range(0, max_gap);
                for (int gi = 0; gi < g; gi++) begin
                    bus.v_data_valid = 1'b0;
                    bus.v_ack = 1'($urandom_range(0, 1));
                    step(); cyc++; gaps++;
                end
                bus.v_ack = 1'b0;
                if (fixed_q.size() != 0) w = fixed_q.pop_front();
                else                     w = {$urandom, $urandom};
                bus.v_data_valid = 1'b1;
                bus.v_data = w;
                exp_mem[k] = w;
                step(); cyc++;
            end
            bus.v_data = {$urandom, $urandom};
            step(); cyc++;
            check_val("resp_not_yet", bus.resp_valid, 0);
            check_val("grant_held", bus.grant, oh);
            bus.v_data_valid = 1'b0;
            step(); cyc++;
        end
        check_val("resp_valid", bus.resp_valid, oh);
        check_val("resp_err", bus.resp_err, 0);
        check_val("grant_clear", bus.grant, 0);
        check_val("latency", cyc, (n == 0) ? 2 + ack_dly : 3 + n + ack_dly + gaps);
        for (int k = 0; k < 8; k++) check_val($sformatf("resp_data%0d", k), bus.resp_data[k], exp_mem[k]);
        pend[own] = 1'b0;
        bus.req_valid[own] = 1'b0;
        ptr = (own + 1) % 4;
    endtask

    initial begin
        rstb = 1'b0;
        bus.v_ack = 1'b0;
        bus.v_data_valid = 1'b0;
        bus.v_data = '0;
        for (int i = 0; i < 4; i++) set_req(i, 4'(i + 1), 32'(100 + i), 4'd1);
        apply_reqs();
        model_reset();

        // Reset with every client requesting.
        step(); step();
        check_val("rst_grant", bus.grant, 0);
        check_val("rst_v_req", bus.v_req, 0);
        check_val("rst_resp_valid", bus.resp_valid, 0);
        check_val("rst_resp_err", bus.resp_err, 0);
        check_val("rst_v_id", bus.v_id, 0);
        check_val("rst_v_type", bus.v_type, 0);
        check_val("rst_v_nwords", bus.v_nwords, 0);
        check_val("rst_resp_data", bus.resp_data[0], 0);

        // Single client, words 5,6,7 back-to-back.
        for (int i = 0; i < 4; i++) pend[i] = 1'b0;
        set_req(1, 4'h3, 32'h11, 4'd3);
        apply_reqs();
        fixed_q = '{64'd5, 64'd6, 64'd7};
        rstb = 1'b1;
        run_txn(0, 0, 1'b0);

        // Fairness from a fresh pointer.
        rstb = 1'b0; step(); rstb = 1'b1; model_reset();
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 4; i++) if (!pend[i]) set_req(i, 4'($urandom), $urandom, 4'd1);
            apply_reqs();
            run_txn(0, 0, 1'b0);
        end

        // Clamp with gaps, then zero-length.
        for (int i = 0; i < 4; i++) pend[i] = 1'b0;
        set_req(2, 4'h7, 32'hC1A4, 4'd12);
        apply_reqs();
        run_txn(1, 2, 1'b0);
        set_req(3, 4'h9, 32'h0, 4'd0);
        apply_reqs();
        run_txn(2, 0, 1'b0);

        // Reset during COLLECT.
        set_req(2, 4'h5, 32'hDEAD, 4'd4);
        apply_reqs();
        step();
        check_val("abort_grant", bus.grant, 4'b0100);
        bus.v_ack = 1'b1; step(); bus.v_ack = 1'b0;
        bus.v_data_valid = 1'b1; bus.v_data = 64'h1234; step(); bus.v_data_valid = 1'b0;
        rstb = 1'b0; step();
        model_reset();
        check_val("abort_v_req", bus.v_req, 0);
        check_val("abort_grant0", bus.grant, 0);
        check_val("abort_resp", bus.resp_valid, 0);
        check_val("abort_data", bus.resp_data[0], exp_mem[0]);
        rstb = 1'b1; pend[2] = 1'b0; apply_reqs();
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("abort_no_resp", bus.resp_valid, 0);
        end

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1)
                    set_req(i, 4'($urandom), $urandom, 4'($urandom_range(0, 12)));
            end
            if (!(pend[0] || pend[1] || pend[2] || pend[3]))
                set_req($urandom_range(0, 3), 4'($urandom), $urandom, 4'($urandom_range(0, 12)));
            apply_reqs();
            run_txn($urandom_range(0, 2), 2, 1'($urandom_range(0, 3) == 0));
        end

`ifdef VIF_ARB_TIMEOUT_EN
        begin
            int own, cnt;
            for (int i = 0; i < 4; i++) pend[i] = 1'b0;
            set_req(0, 4'h1, 32'h70, 4'd2);
            set_req(1, 4'h2, 32'h71, 4'd1);
            apply_reqs();
            own = pick_owner();
            step();
            check_val("to_grant", bus.grant, 4'b0001 << own);
            cnt = 0;
            while (bus.resp_valid == 4'b0000 && cnt < 70000) begin
                step(); cnt++;
            end
            check_val("to_cycles", cnt, 65537);
            check_val("to_resp", bus.resp_valid, 4'b0001 << own);
            check_val("to_err", bus.resp_err, 1);
            pend[own] = 1'b0; bus.req_valid[own] = 1'b0;
            ptr = (own + 1) % 4;
            own = pick_owner();
            step();
            check_val("to_next_grant", bus.grant, 4'b0001 << own);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
